// File: rtl/sccb_config_seq_if.sv
// Bus bundle between the SCCB config sequencer, its register table ROM and
// the SCCB byte master. Member names are as seen from the sequencer.
interface sccb_config_seq_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] o_rom_addr;
  logic [15:0]       i_rom_data;
  logic              o_i2c_start;
  logic              o_i2c_stop;
  logic [7:0]        o_i2c_wr_byte;
  logic              i_i2c_tx_done;
  logic              i_i2c_ack;

  modport master (
    output o_rom_addr, o_i2c_start, o_i2c_stop, o_i2c_wr_byte,
    input  i_rom_data, i_i2c_tx_done, i_i2c_ack
  );

  modport slave (
    input  o_rom_addr, o_i2c_start, o_i2c_stop, o_i2c_wr_byte,
    output i_rom_data, i_i2c_tx_done, i_i2c_ack
  );
endinterface

// File: rtl/sccb_config_seq.sv
// SCCB register-programming sequencer. Walks a {reg, data} table and issues
// one 3-byte write (DEV_ADDR, reg, data) per entry; 16'hFFF0 inserts a
// DELAY_MS pause, 16'hFFFF ends the table.
// Optional feature macro: SCCB_RETRY_EN -- re-issue a NACKed entry up to
// MAX_RETRY times before flagging an error.
module sccb_config_seq #(
  parameter int         IP_CLK_FREQ = 50000000,
  parameter logic [7:0] DEV_ADDR    = 8'h42,
  parameter int         DELAY_MS    = 10,
  parameter int         GAP_CYCLES  = 1000,
  parameter int         ADDR_W      = 8,
  parameter int         MAX_RETRY   = 3
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  sccb_config_seq_if.master   bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_nack_err,
  output logic [ADDR_W-1:0]   o_err_addr
);

  localparam int DLY_CYC = DELAY_MS * (IP_CLK_FREQ / 1000);
  localparam int DLY_W   = (DLY_CYC > 0) ? $clog2(DLY_CYC + 1) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = (DLY_CYC > 0) ? DLY_W'(DLY_CYC - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_ADDR,
    S_DATA, S_LAST, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, eaddr_q, eaddr_d;
  logic              start_q, start_d, stop_q, stop_d;
  logic [7:0]        byte_q, byte_d, reg_q, dat_q;
  logic              busy_q, busy_d, done_q, done_d, nerr_q, nerr_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic [DLY_W-1:0]  dcnt_q, dcnt_d;
  logic              nack_now, hold_addr, td, ack;

`ifdef SCCB_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
  logic [RTY_W-1:0] rcnt_q, rcnt_d;
  logic             enack_q, enack_d, redo_q, redo_d;
  assign hold_addr = redo_q;
`else
  assign hold_addr = 1'b0;
`endif

  assign td  = bus.i_i2c_tx_done;
  assign ack = bus.i_i2c_ack;

  assign bus.o_rom_addr    = addr_q;
  assign bus.o_i2c_start   = start_q;
  assign bus.o_i2c_stop    = stop_q;
  assign bus.o_i2c_wr_byte = byte_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_nack_err        = nerr_q;
  assign o_err_addr        = eaddr_q;

  // State, control and output registers; everything clears on reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      eaddr_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nerr_q  <= 1'b0;
      gcnt_q  <= '0;
      dcnt_q  <= '0;
`ifdef SCCB_RETRY_EN
      rcnt_q  <= '0;
      enack_q <= 1'b0;
      redo_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      eaddr_q <= eaddr_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nerr_q  <= nerr_d;
      gcnt_q  <= gcnt_d;
      dcnt_q  <= dcnt_d;
`ifdef SCCB_RETRY_EN
      rcnt_q  <= rcnt_d;
      enack_q <= enack_d;
      redo_q  <= redo_d;
`endif
    end
  end

  // Latch the reg/data bytes of the entry being decoded (data path, no reset).
  always_ff @(posedge i_clk) begin
    if (state_q == S_DECODE) begin
      reg_q <= bus.i_rom_data[15:8];
      dat_q <= bus.i_rom_data[7:0];
    end
  end

  // Next-state and output logic; each byte is staged before its tx_done.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    eaddr_d  = eaddr_q;
    start_d  = start_q;
    stop_d   = stop_q;
    byte_d   = byte_q;
    busy_d   = busy_q;
    done_d   = done_q;
    nerr_d   = nerr_q;
    gcnt_d   = gcnt_q;
    dcnt_d   = dcnt_q;
    nack_now = 1'b0;
`ifdef SCCB_RETRY_EN
    rcnt_d   = rcnt_q;
    enack_d  = enack_q;
    redo_d   = redo_q;
`endif
    case (state_q)
      S_IDLE: if (i_start) begin
        busy_d  = 1'b1;
        done_d  = 1'b0;
        nerr_d  = 1'b0;
        eaddr_d = '0;
        addr_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (bus.i_rom_data == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (bus.i_rom_data == 16'hFFF0) begin
          dcnt_d  = '0;
          state_d = S_DELAY;
        end else begin
          start_d = 1'b1;
          byte_d  = DEV_ADDR;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b0;
        byte_d  = reg_q;
        state_d = S_ADDR;
      end
      S_ADDR: if (td) begin
        byte_d   = dat_q;
        nack_now = ack;
        state_d  = S_DATA;
      end
      S_DATA: if (td) begin
        stop_d   = 1'b1;
        nack_now = ack;
        state_d  = S_LAST;
      end
      S_LAST: if (td) begin
        stop_d   = 1'b0;
        nack_now = ack;
        gcnt_d   = '0;
        state_d  = S_GAP;
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          if (!hold_addr) addr_d = addr_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_DELAY: begin
        if (dcnt_q == DLY_LAST) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SCCB_RETRY_EN
    // A NACK anywhere in the entry is judged once the 3rd byte completes.
    if (state_q == S_DECODE) enack_d = 1'b0;
    if (nack_now) enack_d = 1'b1;
    if (state_q == S_LAST && td && (enack_q || ack)) begin
      if (rcnt_q < RTY_MAX) begin
        rcnt_d = rcnt_q + 1'b1;
        redo_d = 1'b1;
      end else if (!nerr_q) begin
        nerr_d  = 1'b1;
        eaddr_d = addr_q;
      end
    end
    if (state_q == S_GAP && gcnt_q == GAP_LAST) begin
      redo_d = 1'b0;
      if (!redo_q) rcnt_d = '0;
    end
`else
    if (nack_now && !nerr_q) begin
      nerr_d  = 1'b1;
      eaddr_d = addr_q;
    end
`endif
  end

endmodule

// File: doc/sccb_config_seq.md
# sccb_config_seq

Register-programming sequencer that sits directly upstream of the SCCB byte master and drives its start/stop/byte inputs. It walks a table of 16-bit `{reg, data}` entries, issuing one 3-byte SCCB write per entry (`DEV_ADDR`, reg, data). It also handles timed-delay and end-of-table markers. After reset it brings the OV7670 into its configured state before the capture path is enabled.

## Interface
- `IP_CLK_FREQ`, 50000000: i_clk frequency in Hz.
- `DEV_ADDR`, 8'h42: SCCB write address of the sensor.
- `DELAY_MS`, 10: duration of a delay marker, in ms.
- `GAP_CYCLES`, 1000: idle i_clk cycles enforced after each STOP, before the next START.
- `ADDR_W`, 8: table address width.
- `MAX_RETRY`, 3: retries per entry (used only with SCCB_RETRY_EN).

Ports:
- `i_clk` in 1: clock.
- `i_rstn` in 1: reset, synchronous, active-low.
- `i_start` in 1: pulse; starts the sequence from address 0. Ignored unless idle.
- `o_rom_addr` out ADDR_W: table read address.
- `i_rom_data` in 16: table word, valid exactly 1 cycle after o_rom_addr changes.
- `o_i2c_start` out 1: 1-cycle request for a START plus the first byte.
- `o_i2c_stop` out 1: STOP request, sampled by the byte master at tx_done.
- `o_i2c_wr_byte` out 8: next byte for the byte master.
- `i_i2c_tx_done` in 1: 1-cycle pulse at the ACK sample of each byte.
- `i_i2c_ack` in 1: sampled SDA at tx_done (0 = ACK, 1 = NACK).
- `o_busy` out 1: sequence in progress.
- `o_done` out 1: sticky; table end reached.
- `o_nack_err` out 1: sticky; at least one NACK seen.
- `o_err_addr` out ADDR_W: table address of the first NACKed entry.

## Operation
- Reset values: all outputs 0, state IDLE, o_rom_addr 0.
- Entry decode:
  - 16'hFFFF marks end of table, and goes to DONE.
  - 16'hFFF0 marks a delay, and goes to DELAY.
  - Any other word is a write, with reg = [15:8] and data = [7:0].
- States:
  - IDLE: on i_start, set o_busy=1, clear o_done, o_nack_err and address, then go to FETCH.
  - FETCH: wait 1 cycle for ROM data, then go to DECODE.
  - DECODE: act on the entry type as above.
  - START: hold o_i2c_start=1 with o_i2c_wr_byte=DEV_ADDR for 1 cycle, then set o_i2c_wr_byte=reg and go to ADDR.
  - ADDR: on tx_done #1, set wr_byte=data and go to DATA.
  - DATA: on tx_done #2, set o_i2c_stop=1 and go to LAST.
  - LAST: on tx_done #3, set o_i2c_stop=0 and go to GAP.
  - GAP: count GAP_CYCLES, then increment o_rom_addr and go to FETCH.
  - DELAY: count DELAY_MS × IP_CLK_FREQ/1000 cycles, then increment the address and go to FETCH.
  - DONE: set o_done=1 and o_busy=0, then go to IDLE.
- NACK handling: i_i2c_ack is sampled on every tx_done. On the first NACK, set o_nack_err and load o_err_addr. The 3-byte write always completes.
- Address wrap: the address increment from 2^ADDR_W−1 wraps to 0. The table must contain an end marker.
- Delay counter width is $clog2(DELAY_MS·IP_CLK_FREQ/1000+1). Gap counter width is $clog2(GAP_CYCLES+1).

## Timing
- First o_i2c_start occurs 3 cycles after i_start: IDLE→FETCH→DECODE→START.
- o_i2c_wr_byte must already hold the next byte when tx_done arrives. The byte master captures it on that same cycle.
- i_i2c_tx_done pulses outside ADDR/DATA/LAST are ignored.
- i_start while o_busy=1 is ignored.
- Reset mid-transaction returns the block to IDLE within 1 cycle. o_i2c_stop drops, and no STOP is generated. The bus is recovered by the byte master's own reset.
- Entry-to-entry spacing is 3 tx_done pulses + GAP_CYCLES + 2 cycles.

## Configuration
- `SCCB_RETRY_EN` defined: a NACKed entry is re-issued after GAP, up to MAX_RETRY times, with the address unchanged. o_nack_err and o_err_addr are set only if the final retry also NACKs. The retry counter resets per entry.
- Undefined: no retry. Behaviour is as in Operation.

## Test plan
- Table {16'h1280, 16'hFFFF}, all ACK:
  - wr_byte sequence is 42, 12, 80, and o_i2c_stop is high only between tx_done #2 and #3.
  - o_done=1, o_nack_err=0.
- Table {16'h1180, 16'hFFF0, 16'h6B4A, 16'hFFFF}: the gap between the 2nd write's START and the previous GAP end is ≥ 500000 cycles (10 ms @ 50 MHz).
- NACK on byte 2 of entry 1 without the macro:
  - o_nack_err=1, o_err_addr=1.
  - The sequence still reaches DONE.
- With SCCB_RETRY_EN, NACK on the first 2 attempts of entry 0, then ACK:
  - 3 STARTs for address 0, then o_nack_err=0.
- i_start pulsed during a transfer has no effect. A reset asserted at tx_done #2 gives all outputs 0 on the next cycle.
- Table full of writes with no end marker and ADDR_W=2: the address wraps 3→0 and o_done stays 0.
